// File: rtl/ftdi_spi_rx_if.sv
// Byte stream from the FTDI SPI capture FIFO to the downstream consumer.
// Each byte carries its D/C tag and moves on a valid/ready handshake.
interface ftdi_spi_rx_if;
  logic [7:0] m_data;
  logic       m_dc;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_dc, output m_valid, input m_ready);
  modport slave  (input m_data, input m_dc, input m_valid, output m_ready);
endinterface

// File: rtl/ftdi_spi_rx.sv
// Captures the FTDI MPSSE SPI stream (mode 0, MSB first) into D/C-tagged bytes.
// Bytes are buffered in a first-word-fall-through FIFO drained over valid/ready.
module ftdi_spi_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          resn,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  input  logic                          spi_dc,
  ftdi_spi_rx_if.master                 m_if,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] dc_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_prev_r;

  logic                   s_sclk;
  logic                   s_mosi;
  logic                   s_cs_n;
  logic                   s_dc;

  logic [2:0]             bitcnt_r;
  logic [6:0]             shift_r;
  logic                   frame_err_r;

  logic [8:0]             mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            fill_r;
  logic                   m_valid_r;
  logic                   overflow_r;

  logic                   sclk_rise_s;
  logic                   cs_rise_s;
  logic                   push_s;
  logic [8:0]             push_word_s;
  logic                   pop_s;
  logic                   push_ok_s;
  logic [AW:0]            fill_nxt_s;

  assign s_sclk = sclk_sync_r[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_r[SYNC_STAGES-1];
  assign s_cs_n = cs_sync_r[SYNC_STAGES-1];
  assign s_dc   = dc_sync_r[SYNC_STAGES-1];

  // Input synchronisers plus one extra stage of SCLK/CS history for edge detection
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      dc_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], spi_dc};
      sclk_prev_r <= s_sclk;
      cs_prev_r   <= s_cs_n;
    end
  end

  // Edge qualification and the byte/tag formed on the eighth qualified edge
  always_comb begin
    sclk_rise_s = s_sclk & ~sclk_prev_r & ~s_cs_n;
    cs_rise_s   = s_cs_n & ~cs_prev_r;
    push_s      = sclk_rise_s & (bitcnt_r == 3'd7);
    push_word_s = {s_dc, shift_r, s_mosi};
  end

  // Deserialiser: CS high parks the bit counter, so every frame starts at bit 0
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      bitcnt_r    <= 3'd0;
      shift_r     <= 7'd0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= cs_rise_s & (bitcnt_r != 3'd0);
      if (s_cs_n) begin
        bitcnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_r  <= {shift_r[5:0], s_mosi};
        bitcnt_r <= bitcnt_r + 3'd1;
      end
    end
  end

  // FIFO control: a pop in the same cycle frees a slot for the incoming byte
  always_comb begin
    pop_s      = m_valid_r & m_if.m_ready;
    push_ok_s  = push_s & ((fill_r != DEPTH_C) | pop_s);
    fill_nxt_s = fill_r;
    case ({push_ok_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + (AW+1)'(1'b1);
      2'b01:   fill_nxt_s = fill_r - (AW+1)'(1'b1);
      default: fill_nxt_s = fill_r;
    endcase
  end

  // FIFO storage, pointers and registered status
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 9'd0;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fill_r     <= {(AW+1){1'b0}};
      m_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      fill_r    <= fill_nxt_s;
      m_valid_r <= (fill_nxt_s != {(AW+1){1'b0}});
      if (push_s & ~push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign m_if.m_data  = mem_r[rd_ptr_r][7:0];
  assign m_if.m_dc    = mem_r[rd_ptr_r][8];
  assign m_if.m_valid = m_valid_r;
  assign fill         = fill_r;
  assign overflow     = overflow_r;
  assign frame_err    = frame_err_r;

endmodule
